// File: rtl/fft_result_reader.sv
// Unloads N_POINTS results from the FFT result memory (optionally undoing bit-reversed order) onto a valid/ready stream.
// First beat 3 cycles after start; a 2-entry buffer with read credits holds data stable under backpressure at one beat/cycle.
module fft_result_reader #(
  parameter int N_POINTS    = 64,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = $clog2(N_POINTS),
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [ADDR_W-1:0] m_index_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic                infl_q, infl_d;
  logic [ADDR_W-1:0]   tag_q, tag_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          occ_q, occ_d;
  logic [DATA_W-1:0]   dat0_q, dat0_d, dat1_q, dat1_d;
  logic [ADDR_W-1:0]   idx0_q, idx0_d, idx1_q, idx1_d;

  logic                pop;
  logic                issue;
  logic [1:0]          occ_mid;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] r;
    r = k;
    if (BIT_REVERSE) begin
      for (int i = 0; i < ADDR_W; i++) r[i] = k[ADDR_W-1-i];
    end
    return r;
  endfunction

  always_comb begin
    pop     = (occ_q != 2'd0) && m_ready_i;
    // A read may only be issued if a buffer slot is guaranteed free when its data returns.
    issue   = (state_q == READ) && (((occ_q + {1'b0, infl_q}) < 2'd2) || pop);

    state_d = state_q;
    k_d     = k_q;
    infl_d  = issue;
    tag_d   = issue ? k_q : tag_q;
    addr_d  = issue ? map_addr(k_q) : addr_q;

    dat0_d  = dat0_q;
    dat1_d  = dat1_q;
    idx0_d  = idx0_q;
    idx1_d  = idx1_q;
    occ_mid = occ_q - {1'b0, pop};
    if (pop) begin
      dat0_d = dat1_q;
      idx0_d = idx1_q;
    end
    if (infl_q) begin
      if (occ_mid == 2'd0) begin
        dat0_d = rd_data_i;
        idx0_d = tag_q;
      end else begin
        dat1_d = rd_data_i;
        idx1_d = tag_q;
      end
    end
    occ_d = occ_mid + {1'b0, infl_q};

    case (state_q)
      IDLE: begin
        k_d = '0;
        if (start_i) state_d = READ;
      end
      READ: begin
        if (issue) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!infl_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      infl_q  <= 1'b0;
      tag_q   <= '0;
      addr_q  <= '0;
      occ_q   <= 2'd0;
      dat0_q  <= '0;
      dat1_q  <= '0;
      idx0_q  <= '0;
      idx1_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      infl_q  <= infl_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      occ_q   <= occ_d;
      dat0_q  <= dat0_d;
      dat1_q  <= dat1_d;
      idx0_q  <= idx0_d;
      idx1_q  <= idx1_d;
    end
  end

  assign rd_en_o   = issue;
  assign rd_addr_o = issue ? map_addr(k_q) : addr_q;
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = dat0_q;
  assign m_index_o = idx0_q;
  assign m_last_o  = m_valid_o && (idx0_q == LAST_IDX);
  assign busy_o    = (state_q == READ) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);

endmodule
